// File: rtl/usb_rx_control.sv
// USB receive control FSM: validates SYNC, frames data bytes into FIFO writes,
// and checks that SE0 (end of packet) lands on a byte boundary.
module usb_rx_control #(
    parameter logic [7:0] SYNC_BYTE = 8'b1000_0000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SYNC_WAIT = 4'd1,
        SYNC_CHK  = 4'd2,
        RECV      = 4'd3,
        STORE     = 4'd4,
        EOP_WAIT  = 4'd5,
        ERR_DRAIN = 4'd6,
        ERR_WAIT  = 4'd7,
        ERR_IDLE  = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_bit_cnt_next;
    logic               r_eop_pend;
    logic               w_eop_pend_next;
    logic               w_eop_ev;

    assign w_eop_ev = eop & shift_enable;

    // State and framing registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_eop_pend <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_eop_pend <= w_eop_pend_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next    = r_state;
        w_eop_pend_next = r_eop_pend;
        case (r_state)
            IDLE: begin
                if (d_edge) w_state_next = SYNC_WAIT;
            end
            SYNC_WAIT: begin
                if (w_eop_ev)           w_state_next = ERR_DRAIN;
                else if (byte_received) w_state_next = SYNC_CHK;
            end
            SYNC_CHK: begin
                w_state_next = (rcv_data == SYNC_BYTE) ? RECV : ERR_DRAIN;
            end
            RECV: begin
                if (byte_received) begin
                    w_state_next    = STORE;
                    w_eop_pend_next = w_eop_ev;
                end else if (w_eop_ev) begin
                    w_state_next = (r_bit_cnt == '0) ? EOP_WAIT : ERR_DRAIN;
                end
            end
            STORE: begin
                if (r_eop_pend || w_eop_ev) begin
                    w_state_next    = EOP_WAIT;
                    w_eop_pend_next = 1'b0;
                end else begin
                    w_state_next = RECV;
                end
            end
            EOP_WAIT: begin
                if (d_edge) w_state_next = IDLE;
            end
            ERR_DRAIN: begin
                if (w_eop_ev) w_state_next = ERR_WAIT;
            end
            ERR_WAIT: begin
                if (d_edge) w_state_next = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) w_state_next = SYNC_WAIT;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit position within the current data byte; restarts on every entry to RECV
    always_comb begin
        w_bit_cnt_next = r_bit_cnt;
        if ((w_state_next == RECV) && (r_state != RECV)) begin
            w_bit_cnt_next = '0;
        end else if (((r_state == RECV) || (r_state == STORE)) && shift_enable && !eop) begin
            w_bit_cnt_next = CNT_W'(r_bit_cnt + CNT_W'(1));
        end
    end

    // Moore output decode
    always_comb begin
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
        case (r_state)
            SYNC_WAIT, SYNC_CHK, RECV, EOP_WAIT: rcving = 1'b1;
            STORE: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
            end
            ERR_DRAIN: begin
                rcving  = 1'b1;
                r_error = 1'b1;
            end
            ERR_WAIT, ERR_IDLE: r_error = 1'b1;
            default: ;
        endcase
    end

endmodule
